// File: rtl/conn_setup_sequencer_pkg.sv
// Shared types for the connection-setup sequencer: command codes, request record,
// FSM states and the frame-sequence helpers.
package conn_setup_sequencer_pkg;

    typedef enum logic [2:0] {
        CMD_CONN_ID        = 3'd0,
        CMD_OPEN           = 3'd1,
        CMD_DEST_IPV4      = 3'd2,
        CMD_DEST_PORT      = 3'd3,
        CMD_CLIENT_FLOW_ID = 3'd4,
        CMD_QP_FIELDS      = 3'd5,
        CMD_ENABLE         = 3'd6
    } cmd_e;

    typedef struct packed {
        logic        open;
        logic [31:0] conn_id;
        logic [31:0] dest_ip;
        logic [15:0] dest_port;
        logic [15:0] client_flow_id;
        logic [63:0] qp_fields;
    } req_rec_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

    // Frame index within a sequence -> command code; a close skips the address frames.
    function automatic cmd_e frame_code(input logic open, input logic [2:0] idx);
        if (open)
            return (idx >= 3'd6) ? CMD_ENABLE : cmd_e'(idx);
        case (idx)
            3'd0:    return CMD_CONN_ID;
            3'd1:    return CMD_OPEN;
            default: return CMD_ENABLE;
        endcase
    endfunction

    function automatic logic [63:0] frame_data(input req_rec_t rec, input cmd_e code);
        case (code)
            CMD_CONN_ID:        return {32'b0, rec.conn_id};
            CMD_OPEN:           return {63'b0, rec.open};
            CMD_DEST_IPV4:      return {32'b0, rec.dest_ip};
            CMD_DEST_PORT:      return {48'b0, rec.dest_port};
            CMD_CLIENT_FLOW_ID: return {48'b0, rec.client_flow_id};
            CMD_QP_FIELDS:      return rec.qp_fields;
            default:            return 64'b0;
        endcase
    endfunction

endpackage

// File: rtl/conn_setup_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or after the pointer wins.
module conn_setup_sequencer_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    logic [IW:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_k >= (IW+1)'(NUM_REQ))
                w_k = w_k - (IW+1)'(NUM_REQ);
            if (!o_any && i_req[w_k[IW-1:0]]) begin
                o_any                 = 1'b1;
                o_grant[w_k[IW-1:0]]  = 1'b1;
                o_idx                 = w_k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/conn_setup_sequencer.sv
// Shares the RPC unit's connection-setup port between requesters: arbitrates, serialises
// a request into command frames, waits for status (or times out) and returns a response.
module conn_setup_sequencer
    import conn_setup_sequencer_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int REQ_W          = 161
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid_in,
    input  logic [NUM_REQ*REQ_W-1:0] req_data_in,
    output logic [NUM_REQ-1:0]       req_ready_out,
    output logic                     setup_en_out,
    output logic [2:0]               setup_cmd_out,
    output logic [63:0]              setup_data_out,
    input  logic                     status_valid_in,
    input  logic                     status_error_in,
    output logic [NUM_REQ-1:0]       resp_valid_out,
    output logic                     resp_error_out,
    output logic                     resp_timeout_out,
    output logic                     busy_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_e               r_state, w_state_nxt;
    logic [IW-1:0]        r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
    req_rec_t             r_rec, w_rec_nxt;
    logic [2:0]           r_step, w_step_nxt;
    logic [TW-1:0]        r_tmo, w_tmo_nxt;
    logic                 r_err, w_err_nxt, r_to, w_to_nxt;
    logic                 r_en, w_en_nxt;
    cmd_e                 r_cmd, w_cmd_nxt, w_code;
    logic [63:0]          r_data, w_data_nxt;

    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [IW-1:0]        w_arb_idx;
    logic                 w_arb_any;
    req_rec_t             w_req_rec;

    conn_setup_sequencer_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .i_req   (req_valid_in),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    assign w_req_rec = req_rec_t'(req_data_in[w_arb_idx*REQ_W +: REQ_W]);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_nxt     = r_gnt;
        w_rec_nxt     = r_rec;
        w_step_nxt    = r_step;
        w_tmo_nxt     = r_tmo;
        w_err_nxt     = r_err;
        w_to_nxt      = r_to;
        w_en_nxt      = 1'b0;
        w_cmd_nxt     = r_cmd;
        w_data_nxt    = r_data;
        w_code        = CMD_CONN_ID;
        req_ready_out = '0;
        case (r_state)
            ST_IDLE: begin
                // Reset is folded in so the combinational accept never pulses during reset.
                if (!reset && w_arb_any) begin
                    req_ready_out = w_arb_gnt;
                    w_gnt_nxt     = w_arb_gnt;
                    w_rec_nxt     = w_req_rec;
                    w_ptr_nxt     = (w_arb_idx == IW'(NUM_REQ-1)) ? '0 : w_arb_idx + IW'(1);
                    w_step_nxt    = 3'd0;
                    w_en_nxt      = 1'b1;
                    w_cmd_nxt     = CMD_CONN_ID;
                    w_data_nxt    = frame_data(w_req_rec, CMD_CONN_ID);
                    w_state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_cmd == CMD_ENABLE) begin
                    w_tmo_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_code     = frame_code(r_rec.open, r_step + 3'd1);
                    w_step_nxt = r_step + 3'd1;
                    w_en_nxt   = 1'b1;
                    w_cmd_nxt  = w_code;
                    w_data_nxt = frame_data(r_rec, w_code);
                end
            end
            ST_WAIT: begin
                if (status_valid_in) begin
                    w_err_nxt   = status_error_in;
                    w_to_nxt    = 1'b0;
                    w_state_nxt = ST_RESP;
                end else if (r_tmo == TW'(TIMEOUT_CYCLES-1)) begin
                    w_err_nxt   = 1'b1;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            ST_RESP: begin
                w_tmo_nxt   = '0;
                w_step_nxt  = 3'd0;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_rec   <= '0;
            r_step  <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
            r_to    <= 1'b0;
            r_en    <= 1'b0;
            r_cmd   <= CMD_CONN_ID;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_rec   <= w_rec_nxt;
            r_step  <= w_step_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
            r_to    <= w_to_nxt;
            r_en    <= w_en_nxt;
            r_cmd   <= w_cmd_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign setup_en_out     = r_en;
    assign setup_cmd_out    = r_cmd;
    assign setup_data_out   = r_data;
    assign resp_valid_out   = (r_state == ST_RESP) ? r_gnt : '0;
    assign resp_error_out   = (r_state == ST_RESP) & r_err;
    assign resp_timeout_out = (r_state == ST_RESP) & r_to;
    assign busy_out         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_conn_setup_sequencer.sv
// Directed bench for conn_setup_sequencer: frame sequences, arbitration, timeout,
// stray status and mid-sequence reset, with hand-computed expectations.
module tb_conn_setup_sequencer;

    localparam int NUM_REQ = 2;
    localparam int TC      = 16;
    localparam int REQ_W   = 161;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid_in;
    logic [NUM_REQ*REQ_W-1:0] req_data_in;
    logic [NUM_REQ-1:0]       req_ready_out;
    logic                     setup_en_out;
    logic [2:0]               setup_cmd_out;
    logic [63:0]              setup_data_out;
    logic                     status_valid_in;
    logic                     status_error_in;
    logic [NUM_REQ-1:0]       resp_valid_out;
    logic                     resp_error_out;
    logic                     resp_timeout_out;
    logic                     busy_out;

    int nvec = 0;
    int nerr = 0;

    conn_setup_sequencer #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TC), .REQ_W(REQ_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_in     (req_valid_in),
        .req_data_in      (req_data_in),
        .req_ready_out    (req_ready_out),
        .setup_en_out     (setup_en_out),
        .setup_cmd_out    (setup_cmd_out),
        .setup_data_out   (setup_data_out),
        .status_valid_in  (status_valid_in),
        .status_error_in  (status_error_in),
        .resp_valid_out   (resp_valid_out),
        .resp_error_out   (resp_error_out),
        .resp_timeout_out (resp_timeout_out),
        .busy_out         (busy_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, nerr=%0d", nerr);
        $fatal(1);
    end

    function automatic logic [160:0] mkrec(input logic op, input logic [31:0] cid, input logic [31:0] ip,
                                           input logic [15:0] port, input logic [15:0] flow, input logic [63:0] qp);
        return {op, cid, ip, port, flow, qp};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid_in = '0; req_data_in = '0;
        status_valid_in = 1'b0; status_error_in = 1'b0;
        step(); step();
        if ({req_ready_out, setup_en_out, setup_cmd_out, setup_data_out, resp_valid_out,
             resp_error_out, resp_timeout_out, busy_out} !== '0) begin
            $display("FAIL reset_outputs: en=%b cmd=%0d data=%h resp=%b busy=%b want all 0",
                     setup_en_out, setup_cmd_out, setup_data_out, resp_valid_out, busy_out);
            nerr++;
        end
        nvec++;
        reset = 1'b0;
        step();
        if ({setup_en_out, resp_valid_out, busy_out} !== '0) begin
            $display("FAIL reset_idle: en=%b resp=%b busy=%b want 0", setup_en_out, resp_valid_out, busy_out);
            nerr++;
        end
        nvec++;
    endtask

    task automatic test_open();
        logic [63:0] ed [6];
        ed[0] = 64'd5; ed[1] = 64'd1; ed[2] = 64'h0A000002; ed[3] = 64'h1F90; ed[4] = 64'd3;
        ed[5] = 64'h0001FFFF00000011;
        req_data_in[160:0] = mkrec(1'b1, 32'd5, 32'h0A000002, 16'h1F90, 16'd3, 64'h0001FFFF00000011);
        req_valid_in = 2'b01;
        #1;
        if (req_ready_out !== 2'b01) begin
            $display("FAIL open_ready: got %b want 01", req_ready_out); nerr++;
        end
        nvec++;
        for (int i = 0; i < 7; i++) begin
            step();
            req_valid_in = 2'b00;
            if (setup_en_out !== 1'b1 || setup_cmd_out !== 3'(i) || (i < 6 && setup_data_out !== ed[i])) begin
                $display("FAIL open_frame%0d: en=%b cmd=%0d data=%h want en=1 cmd=%0d data=%h",
                         i, setup_en_out, setup_cmd_out, setup_data_out, i, (i < 6) ? ed[i] : 64'h0);
                nerr++;
            end
            nvec++;
        end
        step();
        if (setup_en_out !== 1'b0 || busy_out !== 1'b1 || resp_valid_out !== 2'b00) begin
            $display("FAIL open_wait: en=%b busy=%b resp=%b want 0 1 00", setup_en_out, busy_out, resp_valid_out);
            nerr++;
        end
        nvec++;
        status_valid_in = 1'b1; status_error_in = 1'b0;
        step();
        status_valid_in = 1'b0;
        if ({resp_valid_out, resp_error_out, resp_timeout_out} !== 4'b01_0_0) begin
            $display("FAIL open_resp: resp=%b err=%b to=%b want 01 0 0", resp_valid_out, resp_error_out, resp_timeout_out);
            nerr++;
        end
        nvec++;
        step();
        if (busy_out !== 1'b0 || resp_valid_out !== 2'b00) begin
            $display("FAIL open_idle: busy=%b resp=%b want 0 00", busy_out, resp_valid_out); nerr++;
        end
        nvec++;
    endtask

    task automatic test_close();
        logic [2:0] ec [3];
        logic [63:0] ed [2];
        ec[0] = 3'd0; ec[1] = 3'd1; ec[2] = 3'd6; ed[0] = 64'd5; ed[1] = 64'd0;
        req_data_in[321:161] = mkrec(1'b0, 32'd5, 32'hFFFFFFFF, 16'hAAAA, 16'h5555, 64'hFFFF_FFFF_FFFF_FFFF);
        req_valid_in = 2'b10;
        #1;
        if (req_ready_out !== 2'b10) begin
            $display("FAIL close_ready: got %b want 10", req_ready_out); nerr++;
        end
        nvec++;
        for (int i = 0; i < 3; i++) begin
            step();
            req_valid_in = 2'b00;
            if (setup_en_out !== 1'b1 || setup_cmd_out !== ec[i] || (i < 2 && setup_data_out !== ed[i])) begin
                $display("FAIL close_frame%0d: en=%b cmd=%0d data=%h want en=1 cmd=%0d",
                         i, setup_en_out, setup_cmd_out, setup_data_out, ec[i]);
                nerr++;
            end
            nvec++;
        end
        step();
        if (setup_en_out !== 1'b0) begin
            $display("FAIL close_no_more_frames: en=%b cmd=%0d want en=0", setup_en_out, setup_cmd_out); nerr++;
        end
        nvec++;
        status_valid_in = 1'b1; status_error_in = 1'b1;
        step();
        status_valid_in = 1'b0; status_error_in = 1'b0;
        if ({resp_valid_out, resp_error_out, resp_timeout_out} !== 4'b10_1_0) begin
            $display("FAIL close_resp: resp=%b err=%b to=%b want 10 1 0", resp_valid_out, resp_error_out, resp_timeout_out);
            nerr++;
        end
        nvec++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] g;
        req_data_in[160:0]   = mkrec(1'b0, 32'h10, 32'h0, 16'h0, 16'h0, 64'h0);
        req_data_in[321:161] = mkrec(1'b0, 32'h20, 32'h0, 16'h0, 16'h0, 64'h0);
        req_valid_in = 2'b11;
        for (int t = 0; t < 3; t++) begin
            g = (t == 1) ? 2'b10 : 2'b01;
            #1;
            if (req_ready_out !== g) begin
                $display("FAIL b2b_grant%0d: got %b want %b", t, req_ready_out, g); nerr++;
            end
            nvec++;
            for (int c = 1; c <= 5; c++) begin
                step();
                status_valid_in = 1'b0;
                if (req_ready_out !== 2'b00) begin
                    $display("FAIL b2b_ready_busy%0d_%0d: got %b want 00", t, c, req_ready_out); nerr++;
                end
                nvec++;
                if (c == 1 && setup_data_out !== ((t == 1) ? 64'h20 : 64'h10)) begin
                    $display("FAIL b2b_connid%0d: got %h want %h", t, setup_data_out, (t == 1) ? 64'h20 : 64'h10);
                    nerr++;
                end
                if (c == 1) nvec++;
                if (c == 4) begin
                    status_valid_in = 1'b1; status_error_in = 1'b0;
                end
                if (c == 5) begin
                    if (resp_valid_out !== g || resp_error_out !== 1'b0) begin
                        $display("FAIL b2b_resp%0d: resp=%b err=%b want %b 0", t, resp_valid_out, resp_error_out, g);
                        nerr++;
                    end
                    nvec++;
                end
            end
            step();
        end
        req_valid_in = 2'b00;
    endtask

    task automatic test_timeout();
        req_data_in[160:0] = mkrec(1'b0, 32'h44, 32'h0, 16'h0, 16'h0, 64'h0);
        req_valid_in = 2'b01;
        #1;
        if (req_ready_out !== 2'b01) begin
            $display("FAIL tmo_ready: got %b want 01", req_ready_out); nerr++;
        end
        nvec++;
        step(); req_valid_in = 2'b00;
        step(); step();
        if (setup_cmd_out !== 3'd6 || setup_en_out !== 1'b1) begin
            $display("FAIL tmo_enable: en=%b cmd=%0d want 1 6", setup_en_out, setup_cmd_out); nerr++;
        end
        nvec++;
        for (int k = 0; k < TC; k++) begin
            step();
            if (resp_valid_out !== 2'b00 || busy_out !== 1'b1) begin
                $display("FAIL tmo_wait%0d: resp=%b busy=%b want 00 1", k, resp_valid_out, busy_out); nerr++;
            end
            nvec++;
        end
        step();
        if ({resp_valid_out, resp_error_out, resp_timeout_out} !== 4'b01_1_1) begin
            $display("FAIL tmo_resp: resp=%b err=%b to=%b want 01 1 1", resp_valid_out, resp_error_out, resp_timeout_out);
            nerr++;
        end
        nvec++;
        status_valid_in = 1'b1; status_error_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (resp_valid_out !== 2'b00 || busy_out !== 1'b0) begin
                $display("FAIL tmo_late_status%0d: resp=%b busy=%b want 00 0", k, resp_valid_out, busy_out); nerr++;
            end
            nvec++;
        end
        status_valid_in = 1'b0;
    endtask

    task automatic test_stray_status();
        logic [63:0] ed [6];
        ed[0] = 64'h77; ed[1] = 64'd1; ed[2] = 64'hC0A80101; ed[3] = 64'h0050; ed[4] = 64'hABCD;
        ed[5] = 64'hDEADBEEF00000001;
        status_valid_in = 1'b1; status_error_in = 1'b1;
        step();
        if (resp_valid_out !== 2'b00 || busy_out !== 1'b0) begin
            $display("FAIL stray_idle: resp=%b busy=%b want 00 0", resp_valid_out, busy_out); nerr++;
        end
        nvec++;
        req_data_in[321:161] = mkrec(1'b1, 32'h77, 32'hC0A80101, 16'h0050, 16'hABCD, 64'hDEADBEEF00000001);
        req_valid_in = 2'b10;
        #1;
        if (req_ready_out !== 2'b10) begin
            $display("FAIL stray_ready: got %b want 10", req_ready_out); nerr++;
        end
        nvec++;
        for (int i = 0; i < 7; i++) begin
            step();
            req_valid_in = 2'b00;
            if (setup_en_out !== 1'b1 || setup_cmd_out !== 3'(i) || (i < 6 && setup_data_out !== ed[i])
                || resp_valid_out !== 2'b00) begin
                $display("FAIL stray_frame%0d: en=%b cmd=%0d data=%h resp=%b want en=1 cmd=%0d resp=00",
                         i, setup_en_out, setup_cmd_out, setup_data_out, resp_valid_out, i);
                nerr++;
            end
            nvec++;
        end
        step();
        status_valid_in = 1'b0; status_error_in = 1'b0;
        if (resp_valid_out !== 2'b00 || busy_out !== 1'b1) begin
            $display("FAIL stray_wait0: resp=%b busy=%b want 00 1", resp_valid_out, busy_out); nerr++;
        end
        nvec++;
        step();
        if (resp_valid_out !== 2'b00 || busy_out !== 1'b1) begin
            $display("FAIL stray_wait1: resp=%b busy=%b want 00 1", resp_valid_out, busy_out); nerr++;
        end
        nvec++;
        status_valid_in = 1'b1;
        step();
        status_valid_in = 1'b0;
        if ({resp_valid_out, resp_error_out, resp_timeout_out} !== 4'b10_0_0) begin
            $display("FAIL stray_resp: resp=%b err=%b to=%b want 10 0 0", resp_valid_out, resp_error_out, resp_timeout_out);
            nerr++;
        end
        nvec++;
        step();
    endtask

    task automatic test_reset_mid();
        logic [2:0] ec [3];
        ec[0] = 3'd0; ec[1] = 3'd1; ec[2] = 3'd6;
        req_data_in[160:0] = mkrec(1'b1, 32'd5, 32'h0A000002, 16'h1F90, 16'd3, 64'h0001FFFF00000011);
        req_valid_in = 2'b01;
        step();
        req_valid_in = 2'b00;
        step(); step(); step();
        if (setup_cmd_out !== 3'd3 || setup_en_out !== 1'b1) begin
            $display("FAIL rstmid_4th_frame: en=%b cmd=%0d want 1 3", setup_en_out, setup_cmd_out); nerr++;
        end
        nvec++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        status_valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (setup_en_out !== 1'b0 || busy_out !== 1'b0 || resp_valid_out !== 2'b00) begin
                $display("FAIL rstmid_after%0d: en=%b busy=%b resp=%b want 0 0 00", k, setup_en_out, busy_out, resp_valid_out);
                nerr++;
            end
            nvec++;
            step();
        end
        status_valid_in = 1'b0;
        req_data_in[160:0]   = mkrec(1'b0, 32'h31, 32'h0, 16'h0, 16'h0, 64'h0);
        req_data_in[321:161] = mkrec(1'b0, 32'h32, 32'h0, 16'h0, 16'h0, 64'h0);
        req_valid_in = 2'b11;
        #1;
        if (req_ready_out !== 2'b01) begin
            $display("FAIL rstmid_ptr: got %b want 01", req_ready_out); nerr++;
        end
        nvec++;
        for (int i = 0; i < 3; i++) begin
            step();
            req_valid_in = 2'b00;
            if (setup_en_out !== 1'b1 || setup_cmd_out !== ec[i] || (i == 0 && setup_data_out !== 64'h31)) begin
                $display("FAIL rstmid_frame%0d: en=%b cmd=%0d data=%h want 1 %0d", i, setup_en_out, setup_cmd_out,
                         setup_data_out, ec[i]);
                nerr++;
            end
            nvec++;
        end
        step();
        status_valid_in = 1'b1; status_error_in = 1'b0;
        step();
        status_valid_in = 1'b0;
        if ({resp_valid_out, resp_error_out, resp_timeout_out} !== 4'b01_0_0) begin
            $display("FAIL rstmid_resp: resp=%b err=%b to=%b want 01 0 0", resp_valid_out, resp_error_out, resp_timeout_out);
            nerr++;
        end
        nvec++;
        step();
    endtask

    initial begin
        test_reset();
        test_open();
        test_close();
        test_back_to_back();
        test_timeout();
        test_stray_status();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/conn_setup_sequencer.md
Name: conn_setup_sequencer

Overview:
Controller that shares the RPC unit's single connection-setup command port between NUM_REQ requesters, such as the host MMIO path and the on-NIC management agent.
- Accepts whole connection open/close requests and serialises each into the ordered command-frame sequence the RPC unit expects, one frame per cycle, terminated by the Enable frame.
- Then waits for the RPC unit's setup status, or times out, and returns a per-requester response.

Parameters:
NUM_REQ, 2, number of requesters sharing the setup port (1..8)
TIMEOUT_CYCLES, 1024, cycles spent in WAIT before the request is declared failed (>=2)
REQ_W, 161, bits per request record (see Behaviour)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid_in  in  NUM_REQ  per-requester request valid
req_data_in  in  NUM_REQ*REQ_W  request records; requester k at [k*REQ_W +: REQ_W]
req_ready_out  out  NUM_REQ  one-hot accept pulse; transfer when valid&ready
setup_en_out  out  1  command frame valid
setup_cmd_out  out  3  command code
setup_data_out  out  64  command data, zero-extended
status_valid_in  in  1  RPC unit reports setup result
status_error_in  in  1  result is failure (qualified by status_valid_in)
resp_valid_out  out  NUM_REQ  one-hot response pulse to the granted requester
resp_error_out  out  1  response is failure
resp_timeout_out  out  1  failure caused by timeout
busy_out  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Round-robin pointer 0.
  - Step counter and timeout counter 0.
- Request record, MSB to LSB: open[160], conn_id[159:128], dest_ip[127:96], dest_port[95:80], client_flow_id[79:64], qp_fields[63:0].
- Command codes, from the shared enum:
  - ConnId=0, Open=1, DestIPv4=2, DestPort=3, ClientFlowId=4, QPFields=5, Enable=6.
  - Code 7 is never emitted.
- IDLE:
  - If any req_valid_in is high, grant round-robin starting at the pointer, wrapping NUM_REQ-1 -> 0.
  - Same cycle: pulse req_ready_out[g] and latch the record and g.
  - Pointer <= (g+1) mod NUM_REQ.
  - Next state ISSUE.
  - The grant decision is combinational on req_valid_in; no request is accepted in any other state.
- ISSUE:
  - Emits one frame per cycle, registered; the first frame appears the cycle after the grant.
  - open=1 sequence: ConnId, Open(data=1), DestIPv4, DestPort, ClientFlowId, QPFields, Enable (7 frames).
  - open=0 sequence: ConnId, Open(data=0), Enable (3 frames).
  - Enter WAIT the cycle after Enable is emitted.
  - setup_en_out never has gaps within a sequence.
- WAIT:
  - Timeout counter increments each cycle.
  - status_valid_in=1 -> RESP carrying error=status_error_in, timeout=0.
  - Counter reaches TIMEOUT_CYCLES-1 with no status -> RESP carrying error=1, timeout=1.
  - Status and timeout in the same cycle: status wins.
- RESP:
  - One-cycle pulse of resp_valid_out[g] with resp_error_out/resp_timeout_out valid.
  - Counters cleared; next state IDLE.
  - A new grant is possible the cycle after RESP.
- status_valid_in outside WAIT is ignored.
- Latency: grant at T; open Enable at T+7; earliest response at T+9 (status at T+8). Close Enable at T+3; earliest response at T+5.
- Reset mid-operation (any state): FSM returns to IDLE, frames stop immediately, no response is issued for the in-flight request, pointer returns to 0. Requesters must re-issue.
- Data width: conn_id and dest_ip zero-extended to 64 bits; dest_port and client_flow_id zero-extended from 16 bits.

Decomposition:
- Shared package: command-code enum, request-record struct, and the codes for ConnId..Enable.
- Sub-module rr_arbiter (NUM_REQ): request vector plus pointer in, one-hot grant plus index out, combinational.
- FSM, frame mux and counters stay in conn_setup_sequencer.

Test Plan:
- Open request from req0 (conn_id=5, ip=0x0A000002, port=0x1F90, flow=3, qp=0x0001FFFF00000011), status ok at T+8:
  - Frames: codes 0..6 on cycles T+1..T+7 with matching data.
  - resp_valid_out=01, error=0, at T+9.
- Close request from req1 (conn_id=5), status error:
  - Frames: codes 0, 1(data 0), 6 only.
  - resp_valid_out=10, error=1, timeout=0.
- Both requesters valid continuously:
  - Grants alternate req0, req1, req0.
  - req_ready_out never pulses during ISSUE, WAIT or RESP.
- No status with TIMEOUT_CYCLES=16:
  - Response 16 cycles after entering WAIT, with error=1, timeout=1.
  - Status arriving later is ignored.
- Stray status_valid_in in IDLE and ISSUE:
  - No response; the sequence continues unchanged.
- Reset asserted on the 4th frame:
  - Next cycle setup_en_out=0, busy_out=0, no resp_valid_out.
  - A fresh request after reset completes normally.
